// File: rtl/mem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_if
// Bundles every signal of the memory bus controller except clock and reset.
//
// Core side      : req, addr, wdata, we, load_choice, sw_choice  (to ctrl)
//                  rdata, ready, err, busy                        (from ctrl)
// Default slave  : ds_A, ds_WD, ds_WE, ds_load_choice, ds_sw_choice (from ctrl)
//                  ds_RD                                           (to ctrl)
// Peripheral     : p_valid, p_addr, p_wdata, p_we                  (from ctrl)
//                  p_rdata, p_ready                                (to ctrl)
//
// modport slave  : the controller's view.
// modport master : the environment (core plus both slaves) around it.
// ---------------------------------------------------------------------------
interface mem_bus_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  load_choice;
    logic [2:0]  sw_choice;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    logic [11:0] ds_A;
    logic [31:0] ds_WD;
    logic        ds_WE;
    logic [2:0]  ds_load_choice;
    logic [2:0]  ds_sw_choice;
    logic [31:0] ds_RD;

    logic        p_valid;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    logic [31:0] p_rdata;
    logic        p_ready;

    modport slave (
        input  req, addr, wdata, we, load_choice, sw_choice, ds_RD, p_rdata, p_ready,
        output rdata, ready, err, busy, ds_A, ds_WD, ds_WE, ds_load_choice,
               ds_sw_choice, p_valid, p_addr, p_wdata, p_we
    );

    modport master (
        output req, addr, wdata, we, load_choice, sw_choice, ds_RD, p_rdata, p_ready,
        input  rdata, ready, err, busy, ds_A, ds_WD, ds_WE, ds_load_choice,
               ds_sw_choice, p_valid, p_addr, p_wdata, p_we
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Multi-cycle bus controller between the core load/store path and the
// memory-mapped slaves. Latches one request, checks alignment, then runs the
// access on the fixed-latency default slave (BRAM) or on the valid/ready
// peripheral port, and finishes with a one-cycle ready or err pulse.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - mem_bus_ctrl_if.slave (core, default-slave and peripheral signals)
//
// Parameters:
//   PERIPH_NIBBLE - addr[31:28] value routed to the peripheral port
//   DS_WAIT       - extra default-slave wait cycles (0..15)
//   TIMEOUT       - peripheral wait limit (only with BUS_TIMEOUT_EN)
//
// Optional feature macro: BUS_TIMEOUT_EN - abort peripheral accesses that
// see no p_ready for TIMEOUT cycles.
// ---------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter logic [3:0] PERIPH_NIBBLE = 4'h4,
    parameter int         DS_WAIT       = 0,
    parameter int         TIMEOUT       = 255
) (
    input logic          CLK,
    input logic          RST,
    mem_bus_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DS_ISSUE,
        DS_WAIT_ST,
        DS_READ,
        PERIPH,
        DONE,
        ERR
    } state_t;

    localparam logic [3:0] DS_WAIT_L = 4'(DS_WAIT);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  lc_q;
    logic [2:0]  sc_q;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        misaligned;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
    logic [7:0]  toCnt_q, toCnt_d;
`endif

    // Request check on the live inputs: unknown choice codes count as
    // misaligned so they end in ERR without touching any slave.
    always_comb begin
        misaligned = 1'b1;
        if (bus.we) begin
            unique case (bus.sw_choice)
                3'b001:  misaligned = 1'b0;
                3'b010:  misaligned = bus.addr[0];
                3'b011:  misaligned = (bus.addr[1:0] != 2'b00);
                default: misaligned = 1'b1;
            endcase
        end else begin
            unique case (bus.load_choice)
                3'b001, 3'b010: misaligned = 1'b0;
                3'b011, 3'b100: misaligned = bus.addr[0];
                3'b111:         misaligned = (bus.addr[1:0] != 2'b00);
                default:        misaligned = 1'b1;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            rdata_q   <= 32'd0;
`ifdef BUS_TIMEOUT_EN
            toCnt_q   <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            rdata_q   <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            toCnt_q   <= toCnt_d;
`endif
        end
    end

    // Request capture; only an accepted request (IDLE with req) loads these.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            lc_q    <= 3'd0;
            sc_q    <= 3'd0;
        end else if (state_q == IDLE && bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            lc_q    <= bus.load_choice;
            sc_q    <= bus.sw_choice;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        rdata_d   = rdata_q;
`ifdef BUS_TIMEOUT_EN
        toCnt_d   = toCnt_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BUS_TIMEOUT_EN
                toCnt_d = 8'd0;
`endif
                if (bus.req) begin
                    if (misaligned)
                        state_d = ERR;
                    else if (bus.addr[31:28] == PERIPH_NIBBLE)
                        state_d = PERIPH;
                    else
                        state_d = DS_ISSUE;
                end
            end
            DS_ISSUE: begin
                waitCnt_d = 4'd0;
                state_d   = (DS_WAIT > 0) ? DS_WAIT_ST : DS_READ;
            end
            DS_WAIT_ST: begin
                if (waitCnt_q == DS_WAIT_L - 4'd1)
                    state_d = DS_READ;
                else
                    waitCnt_d = waitCnt_q + 4'd1;
            end
            DS_READ: begin
                if (!we_q)
                    rdata_d = bus.ds_RD;
                state_d = DONE;
            end
            PERIPH: begin
                // p_ready is tested first so it wins over a same-cycle expiry.
                if (bus.p_ready) begin
                    if (!we_q)
                        rdata_d = bus.p_rdata;
                    state_d = DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (toCnt_q == TIMEOUT_L - 8'd1)
                    state_d = ERR;
                else
                    toCnt_d = toCnt_q + 8'd1;
`endif
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; strobes come straight from state_q so an async reset
    // removes them at once.
    always_comb begin
        bus.ready          = (state_q == DONE);
        bus.err            = (state_q == ERR);
        bus.busy           = (state_q != IDLE);
        bus.ds_WE          = (state_q == DS_ISSUE) && we_q;
        bus.ds_load_choice = (state_q == DS_READ) ? lc_q : 3'd0;
        bus.p_valid        = (state_q == PERIPH);
    end

    assign bus.rdata        = rdata_q;
    assign bus.ds_A         = addr_q[13:2];
    assign bus.ds_WD        = wdata_q;
    assign bus.ds_sw_choice = sc_q;
    assign bus.p_addr       = addr_q;
    assign bus.p_wdata      = wdata_q;
    assign bus.p_we         = we_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Directed and randomized transactions against mem_bus_ctrl. Expectations
// come from a transaction-level model: a word array for the default slave,
// completion cycle counts derived from the latency rules, and the alignment
// rule expressed as access size versus byte offset.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;
    localparam int W  = 2;
    localparam int TO = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl #(
        .PERIPH_NIBBLE(4'h4),
        .DS_WAIT      (W),
        .TIMEOUT      (TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Bench-side BRAM: whole-word writes, synchronous read of ds_A.
    logic [31:0] bram [0:4095];
    always @(posedge CLK) begin
        if (bus.ds_WE) bram[bus.ds_A] <= bus.ds_WD;
        bus.ds_RD <= bram[bus.ds_A];
    end

    int          nTotal = 0;
    int          nBad   = 0;
    logic [31:0] refMem [0:15];
    logic [31:0] expRdata = 32'd0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) else begin
            nBad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Alignment rule as size versus offset; unknown choices are invalid.
    function automatic bit refBad(input logic w, input logic [2:0] lc, input logic [2:0] sc,
                                  input logic [1:0] off);
        int size;
        size = 0;
        if (w) begin
            if (sc == 3'd1) size = 1;
            else if (sc == 3'd2) size = 2;
            else if (sc == 3'd3) size = 4;
        end else begin
            if (lc == 3'd1 || lc == 3'd2) size = 1;
            else if (lc == 3'd3 || lc == 3'd4) size = 2;
            else if (lc == 3'd7) size = 4;
        end
        return (size == 0) || ((int'(off) % size) != 0);
    endfunction

    // One full transaction, called at a negedge; returns at a negedge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic w,
                                 input logic [2:0] lc, input logic [2:0] sc,
                                 input int pDelay, input logic [31:0] pData);
        bit          isBad, isPer, isDs, done, gotErr, expErr;
        int          expCycle, expWe, expPv, c, gotCycle, weCnt, pvCycles;
        logic [31:0] expRd, weD, pAddrSeen, pWdSeen;
        logic [11:0] weA;
        logic [2:0]  weSc, lcAt, expLc;
        logic        pWeSeen;

        isBad = refBad(w, lc, sc, a[1:0]);
        isPer = !isBad && (a[31:28] == 4'h4);
        isDs  = !isBad && !isPer;
        expErr = 1'b0;
        expRd  = expRdata;
        if (isBad) begin
            expCycle = 1;
            expErr   = 1'b1;
        end else if (isPer) begin
            if (TIMEOUT_ON && pDelay >= TO) begin
                expCycle = TO + 1;
                expErr   = 1'b1;
            end else begin
                expCycle = pDelay + 2;
                if (!w) expRd = pData;
            end
        end else begin
            expCycle = 3 + W;
            if (!w) expRd = refMem[a[5:2]];
        end
        expWe = (isDs && w) ? 1 : 0;
        expPv = isPer ? expCycle - 1 : 0;
        expLc = isDs ? lc : 3'd0;

        bus.req = 1'b1; bus.addr = a; bus.wdata = wd; bus.we = w;
        bus.load_choice = lc; bus.sw_choice = sc;
        bus.p_rdata = pData; bus.p_ready = 1'b0;
        @(negedge CLK);
        bus.req = 1'b0; bus.addr = $urandom; bus.wdata = $urandom;

        c = 1; done = 0; gotCycle = 0; gotErr = 0; weCnt = 0; pvCycles = 0;
        weA = '0; weD = '0; weSc = '0; lcAt = '0; pAddrSeen = '0; pWdSeen = '0; pWeSeen = 1'b0;
        while (!done && c <= 300) begin
            if (bus.ready || bus.err) begin
                done = 1; gotCycle = c; gotErr = bus.err;
            end else begin
                if (bus.ds_WE) begin
                    weCnt++; weA = bus.ds_A; weD = bus.ds_WD; weSc = bus.ds_sw_choice;
                end
                if (bus.p_valid) begin
                    if (pvCycles == 0) begin
                        pAddrSeen = bus.p_addr; pWdSeen = bus.p_wdata; pWeSeen = bus.p_we;
                    end
                    pvCycles++;
                end
                if (c == expCycle - 1) lcAt = bus.ds_load_choice;
                bus.p_ready = isPer && (c == pDelay + 1);
                @(negedge CLK);
                c++;
            end
        end
        bus.p_ready = 1'b0;

        if (!done) checkOutput("completionWithinBound", 32'd0, 32'd1);
        checkOutput("doneCycle", gotCycle, expCycle);
        checkOutput("errFlag", 32'(gotErr), 32'(expErr));
        checkOutput("rdata", bus.rdata, expRd);
        checkOutput("dsWeCount", weCnt, expWe);
        if (weCnt == 1 && expWe == 1) begin
            checkOutput("dsA", 32'(weA), 32'(a[13:2]));
            checkOutput("dsWD", weD, wd);
            checkOutput("dsSwChoice", 32'(weSc), 32'(sc));
        end
        checkOutput("pValidCycles", pvCycles, expPv);
        if (pvCycles > 0 && expPv > 0) begin
            checkOutput("pAddr", pAddrSeen, a);
            checkOutput("pWdata", pWdSeen, wd);
            checkOutput("pWe", 32'(pWeSeen), 32'(w));
        end
        if (expCycle > 1) checkOutput("dsLoadChoice", 32'(lcAt), 32'(expLc));

        @(negedge CLK);
        checkOutput("pulseEnd", {29'd0, bus.busy, bus.ready, bus.err}, 32'd0);

        expRdata = expRd;
        if (isDs && w) refMem[a[5:2]] = wd;
    endtask

    int          lcTab [5] = '{1, 2, 3, 4, 7};
    int          scTab [3] = '{1, 2, 3};

    initial begin
        logic [31:0] a, wd, r1Data;
        logic [2:0]  lc, sc;
        logic [3:0]  nib;
        logic [1:0]  off;
        logic        w;
        bit          per;
        int          r1, r2;

        bus.req = 1'b0; bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
        bus.load_choice = '0; bus.sw_choice = '0; bus.p_rdata = '0; bus.p_ready = 1'b0;

        // Reset state
        #22;
        checkOutput("resetCtl", {26'd0, bus.ready, bus.err, bus.busy, bus.ds_WE, bus.p_valid, 1'b0}, 32'd0);
        checkOutput("resetRdata", bus.rdata, 32'd0);
        checkOutput("resetDsA", 32'(bus.ds_A), 32'd0);
        checkOutput("resetPaddr", bus.p_addr, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        $display("[TB] prefill default slave words 0..15");
        for (int i = 0; i < 16; i++)
            applyStimulus({26'd0, 4'(i), 2'b00}, $urandom, 1'b1, 3'd0, 3'd3, 0, 32'd0);

        $display("[TB] directed store/load, errors, peripheral");
        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 3'd0, 3'd3, 0, 32'd0);
        applyStimulus(32'h0000_0010, 32'h0, 1'b0, 3'd7, 3'd0, 0, 32'd0);
        applyStimulus(32'h0000_0003, 32'h0, 1'b0, 3'd3, 3'd0, 0, 32'd0);
        applyStimulus(32'h0000_0020, 32'h5555_AAAA, 1'b1, 3'd0, 3'd7, 0, 32'd0);
        applyStimulus(32'h4000_0008, 32'h0, 1'b0, 3'd7, 3'd0, 5, 32'h1234_5678);
        applyStimulus(32'h4000_000C, 32'hCAFE_F00D, 1'b1, 3'd0, 3'd3, 0, 32'h1111_1111);
        if (TIMEOUT_ON) begin
            applyStimulus(32'h4000_0010, 32'h0, 1'b0, 3'd7, 3'd0, 1000, 32'h2222_2222);
            applyStimulus(32'h4000_0014, 32'h0, 1'b0, 3'd7, 3'd0, TO - 1, 32'h3333_3333);
        end

        $display("[TB] back-to-back with req held high");
        bus.req = 1'b1; bus.we = 1'b0; bus.load_choice = 3'd7; bus.sw_choice = 3'd0;
        bus.addr = 32'h0000_0004;
        r1 = 0; r2 = 0; r1Data = '0;
        @(negedge CLK);
        bus.addr = 32'h0000_0008;
        for (int c = 1; c <= 40 && r2 == 0; c++) begin
            if (bus.ready) begin
                if (r1 == 0) begin r1 = c; r1Data = bus.rdata; end
                else begin r2 = c; bus.req = 1'b0; end
            end
            if (r1 != 0 && c == r1 + 1) checkOutput("b2bIdleGap", 32'(bus.busy), 32'd0);
            if (r2 == 0) @(negedge CLK);
        end
        bus.req = 1'b0;
        checkOutput("b2bFirstReady", r1, 3 + W);
        checkOutput("b2bFirstData", r1Data, refMem[1]);
        checkOutput("b2bPeriod", r2 - r1, 4 + W);
        checkOutput("b2bSecondData", bus.rdata, refMem[2]);
        expRdata = refMem[2];
        @(negedge CLK);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            w   = 1'($urandom_range(0, 1));
            per = ($urandom_range(0, 2) == 0);
            lc  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(lcTab[$urandom_range(0, 4)]);
            sc  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(scTab[$urandom_range(0, 2)]);
            off = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            nib = 4'($urandom_range(0, 14));
            if (nib >= 4'd4) nib = nib + 4'd1;
            if (per) nib = 4'h4;
            wd = $urandom;
            a  = {nib, 14'($urandom), 8'h00, 4'($urandom_range(0, 15)), off};
            applyStimulus(a, wd, w, lc, sc, $urandom_range(0, 12), $urandom);
        end

        $display("[TB] reset during store issue and during peripheral wait");
        bus.req = 1'b1; bus.addr = 32'h0000_0030; bus.wdata = 32'h0BAD_0BAD;
        bus.we = 1'b1; bus.sw_choice = 3'd3; bus.load_choice = 3'd0;
        @(negedge CLK);
        bus.req = 1'b0;
        checkOutput("issueWeBeforeReset", 32'(bus.ds_WE), 32'd1);
        #1 RST = 1'b0;
        #1;
        checkOutput("issueResetCtl", {27'd0, bus.ready, bus.err, bus.busy, bus.ds_WE, bus.p_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("quietAfterReset", {29'd0, bus.busy, bus.ready, bus.err}, 32'd0);
        end

        bus.req = 1'b1; bus.addr = 32'h4000_0040; bus.we = 1'b0;
        bus.load_choice = 3'd7; bus.p_ready = 1'b0;
        @(negedge CLK);
        bus.req = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("pValidBeforeReset", 32'(bus.p_valid), 32'd1);
        #2 RST = 1'b0;
        #1;
        checkOutput("periphResetCtl", {27'd0, bus.ready, bus.err, bus.busy, bus.ds_WE, bus.p_valid}, 32'd0);
        checkOutput("periphResetRdata", bus.rdata, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        expRdata = 32'd0;
        @(negedge CLK);
        checkOutput("idleAfterRelease", {29'd0, bus.busy, bus.ready, bus.err}, 32'd0);
        applyStimulus(32'h0000_0030, 32'h0, 1'b0, 3'd7, 3'd0, 0, 32'd0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
